// File: rtl/alu_pkg.sv
// Op codes and FSM state encoding shared by the sequential ALU and its iterative datapath.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

endpackage

// File: rtl/alu_iter.sv
// Shared one-bit-per-cycle datapath: unsigned shift-add multiply and restoring divide.
// lo/hi present the result of the current step, so they are final while done is high.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic             busy_q, div_q;
  logic [CW-1:0]    cnt_q;
  // acc holds product high / partial remainder; sh holds multiplier / dividend-quotient
  logic [WIDTH-1:0] acc_q, sh_q, opnd_q;
  logic [WIDTH-1:0] acc_nxt, sh_nxt;
  logic [WIDTH:0]   mul_sum, div_trial, div_diff;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    acc_nxt   = acc_q;
    sh_nxt    = sh_q;
    mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : '0);
    div_trial = {acc_q, sh_q[WIDTH-1]};
    div_diff  = div_trial - {1'b0, opnd_q};
    if (div_q) begin
      // top bit of the difference is the borrow: set means the trial subtract failed
      acc_nxt = div_diff[WIDTH] ? div_trial[WIDTH-1:0] : div_diff[WIDTH-1:0];
      sh_nxt  = {sh_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      acc_nxt = mul_sum[WIDTH:1];
      sh_nxt  = {mul_sum[0], sh_q[WIDTH-1:1]};
    end
  end

  // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: these are a handful of flops, not a memory, so resetting them all is cheap and keeps sim X-free.
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      sh_q   <= '0;
      opnd_q <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      div_q  <= op_div;
      cnt_q  <= CNT_LAST;
      acc_q  <= '0;
      sh_q   <= a;
      opnd_q <= b;
    end else if (busy_q) begin
      acc_q <= acc_nxt;
      sh_q  <= sh_nxt;
      if (cnt_q == '0) busy_q <= 1'b0;
      else             cnt_q  <= cnt_q - CNT_ONE;
    end
  end

  assign done = busy_q && (cnt_q == '0);
  assign lo   = sh_nxt;
  assign hi   = acc_nxt;

endmodule

// File: rtl/alu_seq.sv
// Execute-stage ALU with valid/ready handshake, registered results and
// multi-cycle unsigned multiply/divide sharing one iterative datapath.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUctl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] hi,
  output logic             ovf,
  output logic             zero
);

  localparam int MSB = WIDTH - 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sum, diff, res_s, res_hi, iter_lo, iter_hi, s_q, hi_q;
  logic             ovf_add, ovf_sub, res_ovf, ovf_q;
  logic             accept, long_op, iter_done;

  assign sum     = a + b;
  assign diff    = a - b;
  assign ovf_add = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
  assign ovf_sub = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);

  always_comb begin
    res_s   = '0;
    res_hi  = '0;
    res_ovf = 1'b0;
    case (ALUctl)
      OP_AND: res_s = a & b;
      OP_OR:  res_s = a | b;
      OP_NOR: res_s = ~(a | b);
      OP_ADD: begin res_s = sum;  res_ovf = ovf_add; end
      OP_SUB: begin res_s = diff; res_ovf = ovf_sub; end
      OP_SLT: res_s = {{(WIDTH-1){1'b0}}, diff[MSB] ^ ovf_sub};
      // divide by zero resolves here; MULU by zero falls through to zero
      OP_DIVU: if (b == '0) begin res_s = '1; res_hi = a; end
      default: ;
    endcase
  end

  assign long_op = ((ALUctl == OP_MULU) || (ALUctl == OP_DIVU)) && (b != '0);
  assign accept  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = long_op ? BUSY : DONE;
      BUSY: if (iter_done) state_d = DONE;
      DONE: begin
        if (accept)         state_d = long_op ? BUSY : DONE;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q   <= '0;
      hi_q  <= '0;
      ovf_q <= 1'b0;
    end else if (accept && !long_op) begin
      s_q   <= res_s;
      hi_q  <= res_hi;
      ovf_q <= res_ovf;
    end else if ((state_q == BUSY) && iter_done) begin
      s_q   <= iter_lo;
      hi_q  <= iter_hi;
      ovf_q <= 1'b0;
    end
  end

  assign s    = s_q;
  assign hi   = hi_q;
  assign ovf  = ovf_q;
  assign zero = (s_q == '0);

  alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && long_op),
    .op_div (ALUctl == OP_DIVU),
    .a      (a),
    .b      (b),
    .done   (iter_done),
    .lo     (iter_lo),
    .hi     (iter_hi)
  );

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed literal cases plus randomized traffic
// compared every cycle against a transaction-level arithmetic model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0]   ALUctl = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, ovf, zero;
  logic [W-1:0] s, hi;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  logic [3:0] ops [14] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MULU, OP_DIVU,
                           4'b0011, 4'b1111, OP_ADD, OP_SUB, OP_SLT, OP_AND};

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .ALUctl(ALUctl), .out_valid(out_valid), .out_ready(out_ready), .s(s), .hi(hi),
    .ovf(ovf), .zero(zero)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference result of one operation from plain integer arithmetic.
  function automatic void ref_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] rs, output logic [W-1:0] rh,
                                 output logic rv, output bit lng);
    longint      sx, sy, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    rs = '0; rh = '0; rv = 1'b0; lng = 1'b0;
    case (op)
      OP_AND: rs = x & y;
      OP_OR:  rs = x | y;
      OP_NOR: rs = ~(x | y);
      OP_ADD: begin r = sx + sy; rs = x + y; rv = (r != longint'($signed(rs))); end
      OP_SUB: begin r = sx - sy; rs = x - y; rv = (r != longint'($signed(rs))); end
      OP_SLT: rs = (sx < sy) ? 1 : 0;
      OP_MULU: begin
        p = {32'b0, x} * {32'b0, y};
        {rh, rs} = p;
        lng = (y != 0);
      end
      OP_DIVU: begin
        if (y == 0) begin rs = '1; rh = x; end
        else begin rs = x / y; rh = x % y; lng = 1'b1; end
      end
      default: ;
    endcase
  endfunction

  // Transaction-level model: result held or pending with a remaining-cycle count.
  int           m_left  = 0;
  logic         m_valid = 1'b0, m_ovf = 1'b0;
  logic [W-1:0] m_s = '0, m_hi = '0, p_s = '0, p_hi = '0;

  task automatic model_step();
    logic [W-1:0] rs, rh;
    logic rv;
    bit lng;
    if (rst) begin
      m_left = 0; m_valid = 1'b0; m_s = '0; m_hi = '0; m_ovf = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_valid = 1'b1; m_s = p_s; m_hi = p_hi; m_ovf = 1'b0; end
    end else if (in_valid && (!m_valid || out_ready)) begin
      ref_op(ALUctl, a, b, rs, rh, rv, lng);
      if (lng) begin m_left = W; m_valid = 1'b0; p_s = rs; p_hi = rh; end
      else begin m_valid = 1'b1; m_s = rs; m_hi = rh; m_ovf = rv; end
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    #1;
    if (chk_en) begin
      check("model_out_valid", out_valid, m_valid);
      check("model_in_ready", in_ready, (m_left == 0) && (!m_valid || out_ready));
      if (m_valid) begin
        check("model_s", s, m_s);
        check("model_hi", hi, m_hi);
        check("model_ovf", ovf, m_ovf);
        check("model_zero", zero, m_s == 0);
      end
    end
  end

  // Present one operation and hold it until accepted; returns just after the accept edge.
  task automatic send(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input logic rdy);
    int n = 0;
    @(negedge clk);
    ALUctl = op; a = x; b = y; out_ready = rdy; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 100) begin @(negedge clk); #1; n++; end
    check("accept_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
  endtask

  task automatic wait_result(output int edges, output bit ir_low);
    edges = 0; ir_low = 1'b1;
    while (!out_valid && edges < 100) begin
      ir_low = ir_low & !in_ready;
      @(negedge clk); #1;
      edges++;
    end
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int edges;
    bit ir_low;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_s", s, 0);
    check("rst_hi", hi, 0);
    check("rst_ovf", ovf, 0);
    check("rst_zero", zero, 1);
    check("rst_in_ready", in_ready, 1);
    chk_en = 1'b1;

    send(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1);
    check("add_valid", out_valid, 1);
    check("add_s", s, 32'h8000_0000);
    check("add_ovf", ovf, 1);

    send(OP_SUB, 32'd5, 32'd5, 1'b1);
    check("sub_s", s, 0);
    check("sub_zero", zero, 1);
    check("sub_ovf", ovf, 0);

    send(OP_SLT, 32'h8000_0000, 32'h1, 1'b1);
    check("slt_s", s, 1);

    send(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_result(edges, ir_low);
    check("mulu_latency", edges, 32);
    check("mulu_in_ready_low", ir_low, 1);
    check("mulu_hi", hi, 32'hFFFF_FFFE);
    check("mulu_s", s, 32'h0000_0001);

    send(OP_DIVU, 32'd100, 32'd7, 1'b1);
    wait_result(edges, ir_low);
    check("divu_latency", edges, 32);
    check("divu_s", s, 14);
    check("divu_hi", hi, 2);

    send(OP_DIVU, 32'd9, 32'd0, 1'b1);
    check("div0_valid", out_valid, 1);
    check("div0_s", s, 32'hFFFF_FFFF);
    check("div0_hi", hi, 9);

    send(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("bp_s", s, 32'hF000_F000);
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    send(OP_OR, 32'h0F0F_0000, 32'h0000_00F0, 1'b1);
    check("bp_or_valid", out_valid, 1);
    check("bp_or_s", s, 32'h0F0F_00F0);

    send(OP_MULU, 32'd12345, 32'd678, 1'b1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    send(OP_ADD, 32'd2, 32'd3, 1'b1);
    check("post_rst_add_s", s, 5);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      ALUctl    = ops[$urandom_range(0, 13)];
      a         = pick_val();
      b         = pick_val();
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) @(negedge clk);
    #2;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "time limit");
  end

endmodule
